if_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core, sitting directly upstream of the instruction-decode stage. It owns the program counter, drives the word address of the instruction memory, and registers the fetched instruction together with PC+4 into the IF/ID pipeline register consumed by decode. It supports stall from the hazard unit and redirect (branch/jump) from later stages, squashing the wrong-path instruction.

---
 rtl/if_stage_pkg.sv | 9 +
 rtl/if_stage_pc_register.sv | 29 ++
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction width,
// the NOP encoding used for squashed slots and the default reset PC.
package if_stage_pkg;

    localparam int                 INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/if_stage_pc_register.sv
// Program-counter register: synchronous active-high reset to RESET_PC,
// loads i_d whenever i_load is high, otherwise holds.
module pc_register
    import if_stage_pkg::*;
#(
    parameter int               NBits    = INSTR_W,
    parameter logic [NBits-1:0] RESET_PC = NBits'(DEFAULT_RESET_PC)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [NBits-1:0] i_d,
    output logic [NBits-1:0] o_q
);

    logic [NBits-1:0] r_pc;

    // PC state: reset wins, then load, otherwise hold
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_d;
        end
    end

    assign o_q = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory word
// address and registers {instruction, PC+4, valid} into IF/ID.
// Optional build macro IF_BRANCH_DELAY_SLOT_EN: a redirect no longer squashes
// the instruction fetched alongside it (MIPS delay-slot behaviour).
//
// Flow control: there is no valid/ready handshake. stall is a level-sensitive
// hold request from the hazard unit and may stay high indefinitely; a redirect
// always overrides it for the PC, and reset overrides everything.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int               NBits        = INSTR_W,
    parameter int               MEMORY_DEPTH = 512,
    parameter logic [NBits-1:0] RESET_PC     = NBits'(DEFAULT_RESET_PC)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            redirect_valid,
    input  logic [NBits-1:0]                redirect_pc,
    output logic [$clog2(MEMORY_DEPTH)-1:0] imem_addr,
    input  logic [NBits-1:0]                imem_data,
    output logic [NBits-1:0]                pc_out,
    output logic [NBits-1:0]                ifid_instr,
    output logic [NBits-1:0]                ifid_pc_plus4,
    output logic                            ifid_valid,
    output logic                            addr_error
);

    localparam int               AW       = $clog2(MEMORY_DEPTH);
    // One past the last byte address covered by instruction memory; one bit
    // wider than the PC so the bound cannot overflow.
    localparam logic [NBits:0]   PC_LIMIT = {1'b0, RESET_PC} + (NBits+1)'(4 * MEMORY_DEPTH);
    localparam logic [NBits-1:0] NOP_W    = NBits'(NOP_INSTR);

    logic [NBits-1:0] w_pc;
    logic [NBits-1:0] w_pc_plus4;
    logic [NBits-1:0] w_redirect_tgt;
    logic [NBits-1:0] w_next_pc;
    logic [NBits-1:0] w_offset;
    logic             w_pc_load;
    logic             w_misaligned;
    logic             w_out_of_range;
    logic             w_fault;

    logic [NBits-1:0] r_ifid_instr;
    logic [NBits-1:0] r_ifid_pc_plus4;
    logic             r_ifid_valid;
    logic             r_addr_error;

    pc_register #(
        .NBits    (NBits),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_pc_load),
        .i_d     (w_next_pc),
        .o_q     (w_pc)
    );

    // Next-PC selection and fetch-address / fault decode
    always_comb begin
        w_pc_plus4     = w_pc + NBits'(4);
        w_redirect_tgt = {redirect_pc[NBits-1:2], 2'b00};
        w_pc_load      = redirect_valid | ~stall;
        w_next_pc      = redirect_valid ? w_redirect_tgt : w_pc_plus4;
        w_misaligned   = redirect_valid && (redirect_pc[1:0] != 2'b00);
        w_out_of_range = (w_next_pc < RESET_PC) || ({1'b0, w_next_pc} >= PC_LIMIT);
        w_fault        = w_pc_load && (w_misaligned || w_out_of_range);
        // Word offset from the memory base; high bits simply wrap away.
        w_offset       = w_pc - RESET_PC;
    end

    assign imem_addr = AW'(w_offset >> 2);
    assign pc_out    = w_pc;

    // IF/ID pipeline register: reset > redirect > stall > advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid_instr    <= NOP_W;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
        end else if (redirect_valid) begin
`ifdef IF_BRANCH_DELAY_SLOT_EN
            if (!stall) begin
                r_ifid_instr    <= imem_data;
                r_ifid_pc_plus4 <= w_pc_plus4;
                r_ifid_valid    <= 1'b1;
            end
`else
            r_ifid_instr    <= NOP_W;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
`endif
        end else if (!stall) begin
            r_ifid_instr    <= imem_data;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_valid    <= 1'b1;
        end
    end

    // Sticky fetch-address fault, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_error <= 1'b0;
        end else if (w_fault) begin
            r_addr_error <= 1'b1;
        end
    end

    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign ifid_valid    = r_ifid_valid;
    assign addr_error    = r_addr_error;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table-driven directed vectors, hand-written multi-cycle
// sequences and a randomised run against a behavioural model, all checked
// through one expected-value queue.
module tb_if_stage;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          EW   = 32 * 3 + 2 + 9;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [8:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        addr_error;

    logic [31:0] mem [512];

    int total;
    int bad;

    logic [EW-1:0] exp_q[$];

    if_stage #(
        .NBits        (32),
        .MEMORY_DEPTH (512),
        .RESET_PC     (BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .pc_out         (pc_out),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_valid     (ifid_valid),
        .addr_error     (addr_error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational instruction memory
    assign imem_data = mem[imem_addr];

    function automatic logic [8:0] word_of(input logic [31:0] pc);
        logic [31:0] off;
        off = (pc - BASE) >> 2;
        return off[8:0];
    endfunction

    function automatic logic [EW-1:0] pk(input logic [31:0] pc, input logic [31:0] instr,
                                         input logic [31:0] pc4, input logic v, input logic err);
        return {pc, instr, pc4, v, err, word_of(pc)};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: pop one expected record and compare all outputs
    task automatic check_out();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL queue: got empty expected non-empty");
            return;
        end
        e = exp_q.pop_front();
        cmp("pc_out",        pc_out,                 e[EW-1 -: 32]);
        cmp("ifid_instr",    ifid_instr,             e[EW-33 -: 32]);
        cmp("ifid_pc_plus4", ifid_pc_plus4,          e[EW-65 -: 32]);
        cmp("ifid_valid",    {31'd0, ifid_valid},    {31'd0, e[10]});
        cmp("addr_error",    {31'd0, addr_error},    {31'd0, e[9]});
        cmp("imem_addr",     {23'd0, imem_addr},     {23'd0, e[8:0]});
    endtask

    // driver: apply one cycle of inputs, record expectation, sample after edge
    task automatic apply(input logic s, input logic rv, input logic [31:0] rpc,
                         input logic [EW-1:0] e);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    typedef struct {
        logic        s;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        v;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    // behavioural model state for the random phase
    logic [31:0] m_pc, m_instr, m_pc4, tgt;
    logic        m_v, m_err;
    logic        s, rv;
    logic [31:0] rpc;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;

        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        tbl[0]  = '{0, 0, 32'h0,         32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1, 0};
        tbl[1]  = '{0, 0, 32'h0,         32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1, 0};
        tbl[2]  = '{1, 0, 32'h0,         32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1, 0};
        tbl[3]  = '{1, 0, 32'h0,         32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1, 0};
        tbl[4]  = '{1, 0, 32'h0,         32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1, 0};
        tbl[5]  = '{0, 0, 32'h0,         32'h0040_000C, 32'h1000_0002, 32'h0040_000C, 1, 0};
`ifdef IF_BRANCH_DELAY_SLOT_EN
        tbl[6]  = '{0, 1, 32'h0040_0100, 32'h0040_0100, 32'h1000_0003, 32'h0040_0010, 1, 0};
`else
        tbl[6]  = '{0, 1, 32'h0040_0100, 32'h0040_0100, 32'h0,         32'h0,         0, 0};
`endif
        tbl[7]  = '{0, 0, 32'h0,         32'h0040_0104, 32'h1000_0040, 32'h0040_0104, 1, 0};
`ifdef IF_BRANCH_DELAY_SLOT_EN
        tbl[8]  = '{1, 1, 32'h0040_0200, 32'h0040_0200, 32'h1000_0040, 32'h0040_0104, 1, 0};
`else
        tbl[8]  = '{1, 1, 32'h0040_0200, 32'h0040_0200, 32'h0,         32'h0,         0, 0};
`endif
        tbl[9]  = '{0, 0, 32'h0,         32'h0040_0204, 32'h1000_0080, 32'h0040_0204, 1, 0};
`ifdef IF_BRANCH_DELAY_SLOT_EN
        tbl[10] = '{0, 1, 32'h0040_0102, 32'h0040_0100, 32'h1000_0081, 32'h0040_0208, 1, 1};
`else
        tbl[10] = '{0, 1, 32'h0040_0102, 32'h0040_0100, 32'h0,         32'h0,         0, 1};
`endif
        tbl[11] = '{0, 0, 32'h0,         32'h0040_0104, 32'h1000_0040, 32'h0040_0104, 1, 1};

        // reset state
        apply(0, 0, 32'h0, pk(BASE, 32'h0, 32'h0, 0, 0));
        apply(0, 0, 32'h0, pk(BASE, 32'h0, 32'h0, 0, 0));
        reset = 1'b0;

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].s, tbl[i].rv, tbl[i].rpc,
                  pk(tbl[i].pc, tbl[i].instr, tbl[i].pc4, tbl[i].v, tbl[i].err));
        end

        // reset asserted together with stall and redirect: reset values win,
        // and the sticky fault is cleared
        reset = 1'b1;
        apply(1, 1, 32'h0040_0300, pk(BASE, 32'h0, 32'h0, 0, 0));
        reset = 1'b0;

        // redirect past the end of memory: fault, address wraps to word 0
`ifdef IF_BRANCH_DELAY_SLOT_EN
        apply(0, 1, 32'h0040_0800, pk(32'h0040_0800, 32'h2008_0001, 32'h0040_0004, 1, 1));
`else
        apply(0, 1, 32'h0040_0800, pk(32'h0040_0800, 32'h0, 32'h0, 0, 1));
`endif
        apply(0, 0, 32'h0, pk(32'h0040_0804, 32'h2008_0001, 32'h0040_0804, 1, 1));

        // long stall holds everything
        for (int i = 0; i < 5; i++)
            apply(1, 0, 32'h0, pk(32'h0040_0804, 32'h2008_0001, 32'h0040_0804, 1, 1));

        // random phase against a behavioural model
        reset = 1'b1;
        apply(0, 0, 32'h0, pk(BASE, 32'h0, 32'h0, 0, 0));
        reset = 1'b0;
        m_pc = BASE; m_instr = '0; m_pc4 = '0; m_v = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFFC;
                2:       rpc = BASE + 32'($urandom_range(0, 2047));
                default: rpc = BASE + (32'($urandom_range(0, 511)) << 2);
            endcase
            if (rv) begin
                tgt = {rpc[31:2], 2'b00};
                if (rpc[1:0] != 2'b00 || tgt < BASE || tgt >= BASE + 32'd2048) m_err = 1'b1;
`ifdef IF_BRANCH_DELAY_SLOT_EN
                if (!s) begin
                    m_instr = mem[word_of(m_pc)];
                    m_pc4   = m_pc + 32'd4;
                    m_v     = 1'b1;
                end
`else
                m_instr = 32'h0;
                m_pc4   = 32'h0;
                m_v     = 1'b0;
`endif
                m_pc = tgt;
            end else if (!s) begin
                m_instr = mem[word_of(m_pc)];
                m_pc4   = m_pc + 32'd4;
                m_v     = 1'b1;
                m_pc    = m_pc + 32'd4;
                if (m_pc < BASE || m_pc >= BASE + 32'd2048) m_err = 1'b1;
            end
            apply(s, rv, rpc, pk(m_pc, m_instr, m_pc4, m_v, m_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
